// File: rtl/rupt_controller.sv
// Interrupt sequencer: latches requests, drains the pipeline by holding fetch,
// then redirects to the winning source's vector with a one-cycle take/flush strobe.
module rupt_controller #(
  parameter int unsigned NUM_RUPT     = 10,
  parameter int unsigned DRAIN_CYCLES = 2,
  parameter logic [11:0] VECTOR_BASE  = 12'o4000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_RUPT-1:0] rupt_req,
  input  logic                inhint,
  input  logic                relint,
  input  logic                resume,
  input  logic                core_stall,
  input  logic                branch_E,
  input  logic                halt,
  input  logic [11:0]         resume_pc,
  output logic                hold_fetch,
  output logic                rupt_take,
  output logic [11:0]         rupt_vector,
  output logic                rupt_active,
  output logic [11:0]         saved_pc,
  output logic [NUM_RUPT-1:0] pending,
  output logic                enabled
);

  localparam int unsigned CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, TAKE, ACTIVE} state_t;

  state_t              state, state_n;
  logic [CNT_W-1:0]    drain_cnt, drain_cnt_n;
  logic [NUM_RUPT-1:0] win_onehot;
  logic [NUM_RUPT-1:0] clear;
  logic [11:0]         win_offset;

  // Scan from the top down so the lowest-index pending bit is the last write.
  always_comb begin
    win_onehot = '0;
    win_offset = '0;
    for (int unsigned i = NUM_RUPT; i > 0; i--) begin
      if (pending[i-1]) begin
        win_onehot      = '0;
        win_onehot[i-1] = 1'b1;
        win_offset      = 12'(i * 4);
      end
    end
  end

  assign clear = (state == TAKE) ? win_onehot : '0;

  always_comb begin
    state_n     = state;
    drain_cnt_n = drain_cnt;
    case (state)
      IDLE: begin
        drain_cnt_n = '0;
        if ((|pending) && enabled && !halt) state_n = DRAIN;
      end
      DRAIN: begin
        if (inhint || halt) begin
          state_n     = IDLE;
          drain_cnt_n = '0;
        end else if (branch_E) begin
          drain_cnt_n = '0;
        end else if (!core_stall) begin
          if (drain_cnt == DRAIN_LAST) begin
            state_n     = TAKE;
            drain_cnt_n = '0;
          end else begin
            drain_cnt_n = drain_cnt + 1'b1;
          end
        end
      end
      TAKE: begin
        state_n     = ACTIVE;
        drain_cnt_n = '0;
      end
      ACTIVE: begin
        if (resume) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      drain_cnt <= '0;
      pending   <= '0;
      enabled   <= 1'b0;
      saved_pc  <= '0;
    end else begin
      state     <= state_n;
      drain_cnt <= drain_cnt_n;
      // A request arriving with its own clear stays pending.
      pending   <= (pending & ~clear) | rupt_req;
      if (inhint)      enabled <= 1'b0;
      else if (relint) enabled <= 1'b1;
      if (state == TAKE) saved_pc <= resume_pc;
    end
  end

  assign hold_fetch  = (state == DRAIN) || (state == TAKE);
  assign rupt_take   = (state == TAKE);
  assign rupt_active = (state == ACTIVE);
  assign rupt_vector = rupt_take ? (VECTOR_BASE + win_offset) : VECTOR_BASE;

endmodule

// File: tb/tb_rupt_controller.sv
// Directed bench for rupt_controller; takes are checked by a queue-driven monitor.
module tb_rupt_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic [9:0]  rupt_req;
  logic        inhint, relint, resume, core_stall, branch_E, halt;
  logic [11:0] resume_pc;
  logic        hold_fetch, rupt_take, rupt_active, enabled;
  logic [11:0] rupt_vector, saved_pc;
  logic [9:0]  pending;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] vec;
    logic [11:0] pc;
    bit          chk_pc;
  } exp_t;

  exp_t        exp_q[$];
  bit          pc_due = 1'b0;
  logic [11:0] pc_exp;

  rupt_controller #(.NUM_RUPT(10), .DRAIN_CYCLES(2), .VECTOR_BASE(12'o4000)) dut (
    .clock      (clock),
    .reset      (reset),
    .rupt_req   (rupt_req),
    .inhint     (inhint),
    .relint     (relint),
    .resume     (resume),
    .core_stall (core_stall),
    .branch_E   (branch_E),
    .halt       (halt),
    .resume_pc  (resume_pc),
    .hold_fetch (hold_fetch),
    .rupt_take  (rupt_take),
    .rupt_vector(rupt_vector),
    .rupt_active(rupt_active),
    .saved_pc   (saved_pc),
    .pending    (pending),
    .enabled    (enabled)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic run_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic expect_take(input int c, input logic [11:0] v, input logic [11:0] pc, input bit cp);
    exp_t e;
    e.cyc = c; e.vec = v; e.pc = pc; e.chk_pc = cp;
    exp_q.push_back(e);
  endtask

  task automatic do_resume();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("resume_active_clear", rupt_active, 1'b0);
  endtask

  task automatic pulse_req(input int idx);
    rupt_req[idx] = 1'b1;
    tick();
    rupt_req = '0;
  endtask

  // Monitor: pops one expectation per observed take strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (pc_due) begin
        chk("saved_pc", saved_pc, pc_exp);
        pc_due = 1'b0;
      end
      if (rupt_take === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_take: got take vector %0o at cycle %0d, required no take", rupt_vector, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("take_cycle", cyc, e.cyc);
          chk("take_vector", rupt_vector, e.vec);
          if (e.chk_pc) begin
            pc_due = 1'b1;
            pc_exp = e.pc;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, r;
    reset = 1'b1; rupt_req = '0; inhint = 0; relint = 0; resume = 0;
    core_stall = 0; branch_E = 0; halt = 0; resume_pc = 12'o1234;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_hold", hold_fetch, 0);
    chk("rst_take", rupt_take, 0);
    chk("rst_active", rupt_active, 0);
    chk("rst_pending", pending, 0);
    chk("rst_enabled", enabled, 0);
    chk("rst_saved_pc", saved_pc, 0);
    chk("rst_vector", rupt_vector, 12'o4000);

    // Basic take of source 0.
    relint = 1'b1; tick(); relint = 1'b0;
    chk("relint_enable", enabled, 1);
    t = cyc;
    expect_take(t + 4, 12'o4004, 12'o1234, 1);
    pulse_req(0);
    chk("t1_pending0", pending[0], 1);
    chk("t1_hold_t1", hold_fetch, 0);
    tick(); chk("t1_hold_t2", hold_fetch, 1);
    tick(); chk("t1_hold_t3", hold_fetch, 1);
    tick(); chk("t1_hold_t4", hold_fetch, 1);
    tick(); chk("t1_active_t5", rupt_active, 1);
    chk("t1_hold_t5", hold_fetch, 0);
    chk("t1_pending_clr", pending[0], 0);
    do_resume();

    // Higher priority arriving during DRAIN wins; lower one follows after resume.
    resume_pc = 12'o0777;
    t = cyc;
    expect_take(t + 4, 12'o4014, 12'o0777, 1);
    pulse_req(6);
    tick();
    pulse_req(2);
    run_until(t + 5);
    chk("t2_pending6", pending, 10'b0001000000);
    r = cyc;
    expect_take(r + 4, 12'o4034, 12'o0777, 1);
    do_resume();
    run_until(r + 5);
    chk("t2_active2", rupt_active, 1);
    do_resume();

    // branch_E in the second DRAIN cycle restarts the count.
    t = cyc;
    expect_take(t + 6, 12'o4020, 12'o0777, 0);
    pulse_req(3);
    run_until(t + 3);
    branch_E = 1'b1; tick(); branch_E = 1'b0;
    chk("t3_hold_branch", hold_fetch, 1);
    run_until(t + 7);
    chk("t3_active", rupt_active, 1);
    do_resume();

    // Three stall cycles in DRAIN delay the take by three.
    t = cyc;
    expect_take(t + 7, 12'o4030, 12'o0777, 0);
    pulse_req(5);
    run_until(t + 2);
    core_stall = 1'b1;
    run_until(t + 5);
    core_stall = 1'b0;
    run_until(t + 8);
    chk("t3_stall_active", rupt_active, 1);
    do_resume();

    // Disabled: request waits without holding fetch.
    inhint = 1'b1; tick(); inhint = 1'b0;
    chk("t4_disabled", enabled, 0);
    pulse_req(4);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("t4_no_hold", hold_fetch, 0);
    end
    chk("t4_pending4", pending[4], 1);
    r = cyc;
    expect_take(r + 4, 12'o4024, 12'o0777, 0);
    relint = 1'b1; tick(); relint = 1'b0;
    run_until(r + 5);
    chk("t4_active", rupt_active, 1);
    do_resume();
    relint = 1'b1; inhint = 1'b1; tick(); relint = 1'b0; inhint = 1'b0;
    chk("t4_both_inhint_wins", enabled, 0);
    relint = 1'b1; tick(); relint = 1'b0;
    chk("t4_reenabled", enabled, 1);

    // Request during ACTIVE waits for resume.
    resume_pc = 12'o2222;
    t = cyc;
    expect_take(t + 4, 12'o4040, 12'o2222, 1);
    pulse_req(7);
    run_until(t + 5);
    pulse_req(1);
    chk("t5_pending1", pending[1], 1);
    repeat (5) tick();
    chk("t5_no_hold_active", hold_fetch, 0);
    chk("t5_still_active", rupt_active, 1);
    r = cyc;
    expect_take(r + 4, 12'o4010, 12'o2222, 1);
    do_resume();
    chk("t5_hold_r1", hold_fetch, 0);
    tick();
    chk("t5_hold_r2", hold_fetch, 1);
    run_until(r + 5);
    chk("t5_active_r5", rupt_active, 1);
    do_resume();

    // inhint during DRAIN abandons the sequence but keeps the request.
    t = cyc;
    pulse_req(8);
    run_until(t + 2);
    chk("t5_drain_hold", hold_fetch, 1);
    inhint = 1'b1; tick(); inhint = 1'b0;
    chk("t5_inhint_hold", hold_fetch, 0);
    chk("t5_inhint_pend", pending[8], 1);
    chk("t5_inhint_en", enabled, 0);
    tick();
    r = cyc;
    expect_take(r + 4, 12'o4044, 12'o2222, 0);
    relint = 1'b1; tick(); relint = 1'b0;
    run_until(r + 5);
    chk("t5_relint_active", rupt_active, 1);
    do_resume();

    // Reset during TAKE.
    t = cyc;
    expect_take(t + 4, 12'o4050, 12'o2222, 0);
    pulse_req(9);
    run_until(t + 4);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_take_rst_hold", hold_fetch, 0);
    chk("t6_take_rst_active", rupt_active, 0);
    chk("t6_take_rst_pend", pending, 0);
    chk("t6_take_rst_en", enabled, 0);
    chk("t6_take_rst_pc", saved_pc, 0);

    // Reset during ACTIVE.
    relint = 1'b1; tick(); relint = 1'b0;
    resume_pc = 12'o3456;
    t = cyc;
    expect_take(t + 4, 12'o4004, 12'o3456, 1);
    pulse_req(0);
    run_until(t + 5);
    chk("t6_pre_active", rupt_active, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_act_rst_active", rupt_active, 0);
    chk("t6_act_rst_hold", hold_fetch, 0);
    chk("t6_act_rst_pend", pending, 0);
    chk("t6_act_rst_en", enabled, 0);
    chk("t6_act_rst_pc", saved_pc, 0);
    repeat (3) tick();

    chk("missing_takes", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
